// File: rtl/heap_array_pkg.sv
// Shared types for the heap-array engine: request opcodes, FSM states, response codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package heap_array_pkg;

    typedef enum logic [2:0] {
        ALLOC  = 3'd0,
        FREE   = 3'd1,
        WRITE  = 3'd2,
        READ   = 3'd3,
        SIZE   = 3'd4,
        INSERT = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PUT   = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/heap_array_memory_freed_stack.sv
// LIFO of freed array ids so the most recently freed array is reused first.
// Latency: push/pop take effect at the clock edge; top is combinational from the stored entries.
// Backpressure: push ignored when full, pop ignored when empty; caller checks empty/full.
module freed_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_m1;

    assign cnt_m1 = cnt - CW'(1);
    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(DEPTH));
    assign top    = mem[cnt_m1[IW-1:0]];

    // Stack pointer and entry storage; entries themselves need no reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
        end else if (push && !full) begin
            mem[cnt[IW-1:0]] <= push_dat;
            cnt              <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt_m1;
        end
    end

endmodule

// File: rtl/heap_array_memory.sv
// Heap of NArrays fixed-area arrays with alloc/free (LIFO reuse), read/write, size and insert-with-shift.
// Latency: single ops respond after handshake edge t+1; INSERT after t+2+(size-index).
// Backpressure: req_ready only in IDLE; response is a one-cycle pulse with no backpressure.
module heap_array_memory
    import heap_array_pkg::*;
#(
    parameter  int MemoryElementWidth = 12,
    parameter  int NArea              = 7,
    parameter  int NArrays            = 4,
    localparam int AW                 = $clog2(NArrays)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [2:0]                    req_op,
    input  logic [AW-1:0]                 req_array,
    input  logic [MemoryElementWidth-1:0] req_index,
    input  logic [MemoryElementWidth-1:0] req_data,
    output logic                          rsp_valid,
    output logic [MemoryElementWidth-1:0] rsp_data,
    output logic                          rsp_error,
    output logic [AW:0]                   live_count
);
    localparam int W  = MemoryElementWidth;
    localparam int HD = NArrays * NArea;
    localparam int HW = $clog2(HD);
    localparam int SW = $clog2(NArea + 1);
    localparam logic [AW:0] MAX_ARR = (AW+1)'(NArrays);

    state_t         state, state_nx;
    logic [W-1:0]   heap   [HD];
    logic [SW-1:0]  size_q [NArrays];
    logic [NArrays-1:0] alloc_q;
    logic [AW:0]    allocs_q, live_q;

    // Response held between the accepting edge and the RESP edge.
    logic           res_err;
    logic [W-1:0]   res_dat;
    logic           ins_rsp_sent;

    // Insert context captured at the handshake.
    logic [AW-1:0]  ins_arr;
    logic [SW-1:0]  ins_idx, ins_cnt;
    logic [W-1:0]   ins_dat;
    logic [HW-1:0]  ins_base;

    op_t            op;
    logic           cur_alloc, idx_ok, acc_ok;
    logic [SW-1:0]  cur_size;
    logic [HW-1:0]  addr;
    logic [W-1:0]   acc_dat;
    logic [AW-1:0]  new_id;
    logic           heap_we;
    logic [HW-1:0]  heap_wa;
    logic [W-1:0]   heap_wd;
    logic           stk_push, stk_pop, stk_empty, stk_full;
    logic [AW-1:0]  stk_top;

    assign op         = op_t'(req_op);
    assign cur_alloc  = alloc_q[req_array];
    assign cur_size   = size_q[req_array];
    assign idx_ok     = (req_index < W'(NArea));
    assign addr       = HW'(req_array) * HW'(NArea) + HW'(req_index);
    assign ins_base   = HW'(ins_arr) * HW'(NArea);
    assign req_ready  = (state == IDLE);
    assign live_count = live_q;

    freed_stack #(.DEPTH(NArrays), .W(AW)) u_freed (
        .clock    (clock),
        .reset    (reset),
        .push     (stk_push),
        .push_dat (req_array),
        .pop      (stk_pop),
        .top      (stk_top),
        .empty    (stk_empty),
        .full     (stk_full)
    );

    // Request decode, next state and the single heap write port.
    always_comb begin
        state_nx = state;
        acc_ok   = 1'b0;
        acc_dat  = '0;
        new_id   = '0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        heap_we  = 1'b0;
        heap_wa  = '0;
        heap_wd  = '0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = RESP;
                    case (op)
                        ALLOC: begin
                            if (!stk_empty) begin
                                acc_ok  = 1'b1;
                                new_id  = stk_top;
                                stk_pop = 1'b1;
                            end else if (allocs_q < MAX_ARR) begin
                                acc_ok = 1'b1;
                                new_id = allocs_q[AW-1:0];
                            end
                            if (acc_ok) acc_dat = W'(new_id);
                        end
                        FREE: begin
                            if (cur_alloc && !stk_full) begin
                                acc_ok   = 1'b1;
                                stk_push = 1'b1;
                            end
                        end
                        WRITE: begin
                            if (cur_alloc && idx_ok) begin
                                acc_ok  = 1'b1;
                                heap_we = 1'b1;
                                heap_wa = addr;
                                heap_wd = req_data;
                            end
                        end
                        READ: begin
                            if (cur_alloc && idx_ok) begin
                                acc_ok  = 1'b1;
                                acc_dat = heap[addr];
                            end
                        end
                        SIZE: begin
                            if (cur_alloc) begin
                                acc_ok  = 1'b1;
                                acc_dat = W'(cur_size);
                            end
                        end
                        INSERT: begin
                            if (cur_alloc && !(req_index > W'(cur_size)) && cur_size != SW'(NArea)) begin
                                acc_ok   = 1'b1;
                                state_nx = SHIFT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SHIFT: begin
                // Move the element just below the counter up by one slot.
                if (ins_cnt > ins_idx) begin
                    heap_we = 1'b1;
                    heap_wa = ins_base + HW'(ins_cnt);
                    heap_wd = heap[ins_base + HW'(ins_cnt) - HW'(1)];
                end else begin
                    state_nx = PUT;
                end
            end
            PUT: begin
                heap_we  = 1'b1;
                heap_wa  = ins_base + HW'(ins_idx);
                heap_wd  = ins_dat;
                state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Heap storage is never cleared; writes are suppressed while reset is asserted.
    always_ff @(posedge clock) begin
        if (reset && heap_we) heap[heap_wa] <= heap_wd;
    end

    // FSM, bookkeeping registers and the registered response pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            alloc_q      <= '0;
            allocs_q     <= '0;
            live_q       <= '0;
            for (int i = 0; i < NArrays; i++) size_q[i] <= '0;
            res_err      <= RSP_OK;
            res_dat      <= '0;
            ins_rsp_sent <= 1'b0;
            ins_arr      <= '0;
            ins_idx      <= '0;
            ins_cnt      <= '0;
            ins_dat      <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_error    <= 1'b0;
        end else begin
            state     <= state_nx;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            if (state == IDLE && req_valid) begin
                res_err <= acc_ok ? RSP_OK : RSP_ERR;
                res_dat <= acc_ok ? acc_dat : '0;
                if (acc_ok) begin
                    case (op)
                        ALLOC: begin
                            alloc_q[new_id] <= 1'b1;
                            size_q[new_id]  <= '0;
                            live_q          <= live_q + 1'b1;
                            if (stk_empty) allocs_q <= allocs_q + 1'b1;
                        end
                        FREE: begin
                            alloc_q[req_array] <= 1'b0;
                            live_q             <= live_q - 1'b1;
                        end
                        WRITE: begin
                            if (req_index >= W'(cur_size))
                                size_q[req_array] <= SW'(req_index) + SW'(1);
                        end
                        INSERT: begin
                            ins_arr <= req_array;
                            ins_idx <= SW'(req_index);
                            ins_cnt <= cur_size;
                            ins_dat <= req_data;
                        end
                        default: ;
                    endcase
                end
            end
            if (state == SHIFT && ins_cnt > ins_idx) ins_cnt <= ins_cnt - SW'(1);
            if (state == PUT) begin
                size_q[ins_arr] <= size_q[ins_arr] + SW'(1);
                rsp_valid       <= 1'b1;
                ins_rsp_sent    <= 1'b1;
            end
            if (state == RESP) begin
                ins_rsp_sent <= 1'b0;
                if (!ins_rsp_sent) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= res_dat;
                    rsp_error <= res_err;
                end
            end
        end
    end

endmodule
